// File: rtl/data_arb_pkg.sv
// Shared types for the data-unit arbiter: FSM states, operand bundle and size limits.
// DATA_ARB_FIXED_PRIO_EN (see data_arb_pick) selects fixed-priority arbitration.
package data_arb_pkg;

  localparam int NREQ_MAX   = 8;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [1:0] data;
    logic [1:0] a;
    logic       s;
  } operand_t;

endpackage

// File: rtl/data_arb_pick.sv
// Combinational request picker: one-hot grant plus binary index of the winner.
// DATA_ARB_FIXED_PRIO_EN defined: lowest index wins, no pointer; otherwise round-robin from ptr_i.
module data_arb_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifndef DATA_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  ptr_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int             j;
  logic [IDW-1:0] jj;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef DATA_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr_i) + k) % NREQ;
`endif
      jj = IDW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/data_unit_arbiter.sv
// Time-shares one combinational 2-bit data unit among NREQ requesters (IDLE -> ISSUE -> RESP).
// Build option DATA_ARB_FIXED_PRIO_EN: fixed priority (lowest index) instead of round-robin.
module data_unit_arbiter
  import data_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int SETTLE = 1,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_a,
  input  logic [NREQ-1:0]   req_s,
  output logic [1:0]        unit_data,
  output logic [1:0]        unit_a,
  output logic              unit_s,
  input  logic [1:0]        unit_d,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_d,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  operand_t        opnd_q;
  operand_t        opnd_d;
  logic [IDW-1:0]  id_q;
  logic            rsp_valid_q;
  logic [1:0]      rsp_d_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win_idx;
  logic            win_any;

`ifndef DATA_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr_q;
`endif

  data_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (req_valid),
`ifndef DATA_ARB_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    opnd_d.data = req_data[{win_idx, 1'b0} +: 2];
    opnd_d.a    = req_a[{win_idx, 1'b0} +: 2];
    opnd_d.s    = req_s[win_idx];
  end

  // Grant is only offered while idle and out of reset, so a handshake implies ownership.
  assign req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;
  assign busy      = (state_q != ST_IDLE);
  assign unit_data = opnd_q.data;
  assign unit_a    = opnd_q.a;
  assign unit_s    = opnd_q.s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_d     = rsp_d_q;
  assign rsp_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_d_q     <= '0;
`ifndef DATA_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            opnd_q  <= opnd_d;
            id_q    <= win_idx;
            cnt_q   <= CNT_W'(SETTLE - 1);
            state_q <= ST_ISSUE;
`ifndef DATA_ARB_FIXED_PRIO_EN
            ptr_q   <= IDW'((int'(win_idx) + 1) % NREQ);
`endif
          end
        end
        // Operands sit on the unit; sample its output once the settle count expires.
        ST_ISSUE: begin
          if (cnt_q == '0) begin
            rsp_d_q     <= unit_d;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
